// File: rtl/wb_intr_aggregator.sv
// wb_intr_aggregator: Wishbone interrupt controller; per-source synchroniser, edge/level pending latch, enable mask, registered INTR_o.
// Define INTR_HOLDOFF_EN to add the HOLDOFF register (word 4) and re-assert holdoff counter.
module wb_intr_aggregator #(
    parameter int NUM_SRC = 4,
    parameter int ADDRWIDTH = 10,
    parameter int DATAWIDTH = 32,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic                 WBs_WE_i,
    input  logic                 WBs_STB_i,
    input  logic [DATAWIDTH-1:0] WBs_DAT_i,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    output logic                 WBs_ACK_o,
    input  logic [NUM_SRC-1:0]   Intr_Src_i,
    output logic                 INTR_o
);
    localparam logic [ADDRWIDTH-1:0] A_RAW  = ADDRWIDTH'(0);
    localparam logic [ADDRWIDTH-1:0] A_PEND = ADDRWIDTH'(1);
    localparam logic [ADDRWIDTH-1:0] A_EN   = ADDRWIDTH'(2);
    localparam logic [ADDRWIDTH-1:0] A_EDGE = ADDRWIDTH'(3);
    localparam logic [ADDRWIDTH-1:0] A_HOLD = ADDRWIDTH'(4);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync, prev, pending, enable, edge_sel, set, clr, wdat;
    logic wr_cyc, wr, irq, intr_nxt, unused;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign wr_cyc = WBs_ACK_o & WBs_WE_i;
    assign wr     = wr_cyc & WBs_BYTE_STB_i[0];
    assign wdat   = WBs_DAT_i[NUM_SRC-1:0];
    // edge mode needs a 0->1 transition; level mode sets on any high sample
    assign set    = sync & ~(edge_sel & prev);
    assign clr    = (wr && WBs_ADR_i == A_PEND) ? wdat : '0;
    assign irq    = |(pending & enable);
    assign unused = ^{WBs_DAT_i, WBs_BYTE_STB_i};

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
        if (WBs_RST_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev      <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_sel  <= '0;
            WBs_ACK_o <= 1'b0;
            INTR_o    <= 1'b0;
        end else begin
            sync_q[0] <= Intr_Src_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev      <= sync;
            pending   <= (pending & ~clr) | set;
            if (wr && WBs_ADR_i == A_EN) enable <= wdat;
            if (wr && WBs_ADR_i == A_EDGE) edge_sel <= wdat;
            WBs_ACK_o <= WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
            INTR_o    <= intr_nxt;
        end

`ifdef INTR_HOLDOFF_EN
    logic [15:0] holdoff, cnt;
    assign intr_nxt = irq & (cnt == '0);
    // counter reloads when INTR_o falls, then counts down and parks at 0
    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
        if (WBs_RST_i) begin
            holdoff <= '0;
            cnt     <= '0;
        end else begin
            if (wr_cyc && WBs_ADR_i == A_HOLD && WBs_BYTE_STB_i[0]) holdoff[7:0] <= WBs_DAT_i[7:0];
            if (wr_cyc && WBs_ADR_i == A_HOLD && WBs_BYTE_STB_i[1]) holdoff[15:8] <= WBs_DAT_i[15:8];
            cnt <= (INTR_o & ~intr_nxt) ? holdoff : cnt - 16'(cnt != '0);
        end
`else
    assign intr_nxt = irq;
`endif

    always_comb begin
        WBs_DAT_o = DEF_REG_VALUE;
        case (WBs_ADR_i)
            A_RAW:  WBs_DAT_o = DATAWIDTH'(sync);
            A_PEND: WBs_DAT_o = DATAWIDTH'(pending);
            A_EN:   WBs_DAT_o = DATAWIDTH'(enable);
            A_EDGE: WBs_DAT_o = DATAWIDTH'(edge_sel);
`ifdef INTR_HOLDOFF_EN
            A_HOLD: WBs_DAT_o = DATAWIDTH'(holdoff);
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_wb_intr_aggregator.sv
// tb_wb_intr_aggregator: directed bench with a per-cycle behavioural model plus literal expectations.
module tb_wb_intr_aggregator;
    localparam int SYNC = 2;
    localparam logic [31:0] DEF = 32'hFABDEFAC;

    logic clk = 0, rst = 1, cyc = 0, stb = 0, we_r = 0, ack, intr;
    logic [9:0] adr_r = '0;
    logic [31:0] dat_r = '0, dat_o, rd;
    logic [3:0] be_r = 4'hF, src = '0;
    int checks = 0, errors = 0, n;

    wb_intr_aggregator dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr_r), .WBs_CYC_i(cyc),
        .WBs_BYTE_STB_i(be_r), .WBs_WE_i(we_r), .WBs_STB_i(stb), .WBs_DAT_i(dat_r),
        .WBs_DAT_o(dat_o), .WBs_ACK_o(ack), .Intr_Src_i(src), .INTR_o(intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model state: hist[k] is the source sample taken k+1 edges ago
    logic [3:0] hist [0:SYNC];
    logic [3:0] m_pend, m_en, m_es;
    logic m_ack, m_intr;
    logic [15:0] m_hold, m_cnt;

    task automatic m_reset();
        for (int k = 0; k <= SYNC; k++) hist[k] = '0;
        m_pend = '0; m_en = '0; m_es = '0; m_ack = 0; m_intr = 0; m_hold = '0; m_cnt = '0;
    endtask

    task automatic m_step();
        logic [3:0] s_now, s_old;
        logic wr, irq, nxt;
        s_now = hist[SYNC-1];
        s_old = hist[SYNC];
        wr = m_ack && we_r && be_r[0];
        irq = |(m_pend & m_en);
        for (int i = 0; i < 4; i++) begin
            if (m_es[i] ? (s_now[i] && !s_old[i]) : s_now[i]) m_pend[i] = 1'b1;
            else if (wr && adr_r == 1 && dat_r[i]) m_pend[i] = 1'b0;
        end
        nxt = irq;
`ifdef INTR_HOLDOFF_EN
        nxt = irq && m_cnt == 0;
        if (m_intr && !nxt) m_cnt = m_hold;
        else if (m_cnt != 0) m_cnt = m_cnt - 1;
        if (m_ack && we_r && adr_r == 4) begin
            if (be_r[0]) m_hold[7:0] = dat_r[7:0];
            if (be_r[1]) m_hold[15:8] = dat_r[15:8];
        end
`endif
        m_intr = nxt;
        if (wr && adr_r == 2) m_en = dat_r[3:0];
        if (wr && adr_r == 3) m_es = dat_r[3:0];
        m_ack = cyc && stb && !m_ack;
        for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = src;
    endtask

    function automatic logic [31:0] m_read(input logic [9:0] a);
        case (a)
            0: return {28'b0, hist[SYNC-1]};
            1: return {28'b0, m_pend};
            2: return {28'b0, m_en};
            3: return {28'b0, m_es};
`ifdef INTR_HOLDOFF_EN
            4: return {16'b0, m_hold};
`endif
            default: return DEF;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        #1;
        if (!rst) begin
            chk("ack", {31'b0, ack}, {31'b0, m_ack});
            chk("intr", {31'b0, intr}, {31'b0, m_intr});
            if (m_ack) chk("rdata", dat_o, m_read(adr_r));
        end
    end

    // caller is just past a negedge; returns just past the negedge after the write edge
    task automatic access(input logic we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, output logic [31:0] r);
        int k;
        cyc = 1; stb = 1; we_r = we; adr_r = a; dat_r = d; be_r = be;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!ack && k < 8);
        if (!ack) chk("ack_timeout", 0, 1);
        r = dat_o;
        @(posedge clk);
        @(negedge clk);
        cyc = 0; stb = 0; we_r = 0; be_r = 4'hF;
    endtask

    task automatic wr_reg(input logic [9:0] a, input logic [31:0] d);
        logic [31:0] junk;
        access(1, a, d, 4'hF, junk);
    endtask

    task automatic rd_chk(input string name, input logic [9:0] a, input logic [31:0] exp);
        logic [31:0] r;
        access(0, a, '0, 4'hF, r);
        chk(name, r, exp);
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        logic v [1:4];
        idle(3);
        rst = 0;
        chk("rst_intr", {31'b0, intr}, 0);
        chk("rst_ack", {31'b0, ack}, 0);
        for (int w = 0; w < 4; w++) rd_chk("rst_read", w[9:0], 0);
`ifdef INTR_HOLDOFF_EN
        rd_chk("rst_read4", 4, 0);
`else
        rd_chk("rst_read4", 4, DEF);
`endif
        rd_chk("rst_read5", 5, DEF);

        wr_reg(2, 32'h3);
        wr_reg(3, 32'h1);
        src[0] = 1;
        @(posedge clk); #1; v[1] = intr;
        @(negedge clk); src[0] = 0;
        for (int k = 2; k <= 4; k++) begin @(posedge clk); #1; v[k] = intr; end
        chk("edge_lat3", {31'b0, v[3]}, 0);
        chk("edge_lat4", {31'b0, v[4]}, 1);
        @(negedge clk);
        rd_chk("edge_pend", 1, 32'h1);
        wr_reg(1, 32'h1);
        chk("w1c_hold", {31'b0, intr}, 1);
        @(posedge clk); #1;
        chk("w1c_fall", {31'b0, intr}, 0);
        @(negedge clk);

        src[1] = 1;
        idle(6);
        chk("lvl_intr", {31'b0, intr}, 1);
        wr_reg(1, 32'h2);
        rd_chk("lvl_repend", 1, 32'h2);
        chk("lvl_stay", {31'b0, intr}, 1);
        src[1] = 0;
        idle(4);
        wr_reg(1, 32'h2);
        rd_chk("lvl_clr", 1, 32'h0);
        chk("lvl_low", {31'b0, intr}, 0);

        wr_reg(3, 32'h5);
        wr_reg(2, 32'h0);
        src[2] = 1;
        idle(1);
        src[2] = 0;
        idle(5);
        rd_chk("mask_pend", 1, 32'h4);
        chk("mask_low", {31'b0, intr}, 0);
        wr_reg(2, 32'h4);
        chk("en_before", {31'b0, intr}, 0);
        @(posedge clk); #1;
        chk("en_rise", {31'b0, intr}, 1);
        @(negedge clk);

        wr_reg(1, 32'hF);
        src[0] = 1;
        idle(1);
        wr_reg(1, 32'h1);
        rd_chk("set_wins", 1, 32'h1);
        src[0] = 0;
        begin
            logic [31:0] junk;
            access(1, 2, 32'h0, 4'b1110, junk);
        end
        rd_chk("be_ignored", 2, 32'h4);

        wr_reg(2, 32'hF);
        idle(2);
        chk("pre_rst_intr", {31'b0, intr}, 1);
        cyc = 1; stb = 1; adr_r = 2;
        @(posedge clk); #1;
        chk("mid_ack", {31'b0, ack}, 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_ack", {31'b0, ack}, 0);
        chk("mid_rst_intr", {31'b0, intr}, 0);
        cyc = 0; stb = 0;
        idle(2);
        rst = 0;
        rd_chk("post_rst_en", 2, 0);
        rd_chk("post_rst_pend", 1, 0);

`ifdef INTR_HOLDOFF_EN
        wr_reg(2, 32'h1);
        wr_reg(3, 32'h1);
        wr_reg(4, 32'd10);
        src[0] = 1;
        idle(1);
        src[0] = 0;
        idle(5);
        chk("ho_intr", {31'b0, intr}, 1);
        wr_reg(1, 32'h1);
        src[0] = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while ((!intr || n < 2) && n < 30);
        chk("ho_rise_edge", n, 12);
        @(negedge clk);
        src[0] = 0;
        idle(3);
        wr_reg(1, 32'h1);
        idle(3);
        #2 rst = 1;
        #1 chk("ho_rst_intr", {31'b0, intr}, 0);
        idle(2);
        rst = 0;
        rd_chk("ho_rst_hold", 4, 0);
        idle(14);
        chk("ho_rst_quiet", {31'b0, intr}, 0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
